risc16_dmem_mmio: RTL

//  Data-side memory system on the risc16b d-port: word RAM plus memory-mapped GPIO, a free-running timer and a UART TX FIFO.

---
 rtl/risc16_dmem_pkg.sv | 31 +++
 rtl/risc16_dmem_mmio_if.sv | 21 ++
 rtl/risc16_uart_tx.sv | 106 ++++++++++
 rtl/risc16_dmem_mmio.sv | 104 ++++++++++
 4 files changed

// File: rtl/risc16_dmem_pkg.sv
// risc16b data-port memory map: address constants, TX states, lane merge.
// Shared by the d-port top level and the UART transmitter.
package risc16_dmem_pkg;

    localparam logic [15:0] MMIO_GPIO  = 16'hFF00;
    localparam logic [15:0] MMIO_TIMER = 16'hFF02;
    localparam logic [15:0] MMIO_UDATA = 16'hFF04;
    localparam logic [15:0] MMIO_USTAT = 16'hFF06;
    localparam logic [15:0] RAM_LIMIT  = 16'h8000;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // we[0] owns the even (high) byte, we[1] the odd (low) byte
    function automatic logic [15:0] merge16(
        input logic [15:0] old_v,
        input logic [15:0] new_v,
        input logic [1:0]  we
    );
        logic [15:0] r;
        r = old_v;
        if (we[0]) r[15:8] = new_v[15:8];
        if (we[1]) r[7:0]  = new_v[7:0];
        return r;
    endfunction

endpackage

// File: rtl/risc16_dmem_mmio_if.sv
// risc16b d-port bundle: core drives address/strobes, memory returns data.
// Reads are combinational, so d_din follows d_addr/d_oe in the same cycle.
interface risc16_dmem_mmio_if;

    logic [15:0] d_addr;
    logic        d_oe;
    logic [15:0] d_dout;
    logic [1:0]  d_we;
    logic [15:0] d_din;

    modport master (
        output d_addr, d_oe, d_dout, d_we,
        input  d_din
    );

    modport slave (
        input  d_addr, d_oe, d_dout, d_we,
        output d_din
    );

endinterface

// File: rtl/risc16_uart_tx.sv
// UART transmitter: byte FIFO, baud counter, 8N1 framing FSM, overflow flag.
// status = {ovf, tx_busy, full, empty}.
module risc16_uart_tx
    import risc16_dmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       clr_ovf,
    output logic       txd,
    output logic [3:0] status
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = ($clog2(BAUD_DIV) > 0) ? $clog2(BAUD_DIV) : 1;

    tx_state_t      state;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     fifo [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;
    logic           ovf;
    logic           empty;
    logic           full;
    logic           bit_end;
    logic           pop;
    logic           push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign bit_end = (baud == BW'(BAUD_DIV - 1));
    // a pop frees a slot this cycle, so a push into a full FIFO still lands
    assign pop     = !empty && ((state == TX_IDLE) ||
                                (state == TX_STOP && bit_end));
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
            if (clr_ovf)               ovf <= 1'b0;
            else if (push && !push_ok) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (state == TX_IDLE) begin
            baud <= '0;
            if (pop) begin
                state <= TX_START;
                shreg <= fifo[rd_ptr];
            end
        end else if (!bit_end) begin
            baud <= baud + BW'(1);
        end else begin
            baud <= '0;
            unique case (state)
                TX_START: begin
                    state   <= TX_DATA;
                    bit_idx <= '0;
                end
                TX_DATA: begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= TX_STOP;
                end
                TX_STOP: begin
                    if (pop) begin
                        state <= TX_START;
                        shreg <= fifo[rd_ptr];
                    end else begin
                        state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    assign txd    = (state == TX_START) ? 1'b0 :
                    (state == TX_DATA)  ? shreg[0] : 1'b1;
    assign status = {ovf, state != TX_IDLE, full, empty};

endmodule

// File: rtl/risc16_dmem_mmio.sv
// risc16b d-port memory: word RAM, GPIO, free-running timer, UART TX.
// Define RISC16_DMEM_UART_EN to build the UART FIFO and transmitter.
module risc16_dmem_mmio
    import risc16_dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 16384,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 868
) (
    input  logic               clk,
    input  logic               rst,
    risc16_dmem_mmio_if.slave  bus,
    output logic [15:0]        gpio_out,
    output logic               uart_txd
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [15:0]   ram [RAM_WORDS];
    logic [15:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic [15:0]   timer;
    logic [15:0]   rdata;
    logic [3:0]    ustat;
    logic          wr;
    logic          ram_hit;
    logic          sel_gpio;
    logic          sel_timer;
    logic          sel_ustat;
    logic          unused_a0;

    assign unused_a0 = bus.d_addr[0];
    assign word_addr = {bus.d_addr[15:1], 1'b0};
    assign ram_idx   = bus.d_addr[AW:1];
    assign wr        = |bus.d_we;
    assign ram_hit   = (word_addr < RAM_LIMIT) &&
                       ({17'b0, bus.d_addr[15:1]} < RAM_WORDS);
    assign sel_gpio  = (word_addr == MMIO_GPIO);
    assign sel_timer = (word_addr == MMIO_TIMER);
    assign sel_ustat = (word_addr == MMIO_USTAT);

    always_ff @(posedge clk) begin
        if (wr && ram_hit)
            ram[ram_idx] <= merge16(ram[ram_idx], bus.d_dout, bus.d_we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= '0;
            timer    <= '0;
        end else begin
            if (wr && sel_gpio)
                gpio_out <= merge16(gpio_out, bus.d_dout, bus.d_we);
            // a load replaces this cycle's increment
            if (wr && sel_timer)
                timer <= merge16(timer, bus.d_dout, bus.d_we);
            else
                timer <= timer + 16'd1;
        end
    end

`ifdef RISC16_DMEM_UART_EN
    logic       sel_udata;
    logic [7:0] push_byte;

    assign sel_udata = (word_addr == MMIO_UDATA);
    assign push_byte = bus.d_we[1] ? bus.d_dout[7:0] : bus.d_dout[15:8];

    risc16_uart_tx #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .BAUD_DIV   (BAUD_DIV)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .push      (wr && sel_udata),
        .push_data (push_byte),
        .clr_ovf   (wr && sel_ustat),
        .txd       (uart_txd),
        .status    (ustat)
    );
`else
    logic unused_cfg;

    assign unused_cfg = (FIFO_DEPTH + BAUD_DIV) > 0;
    assign ustat      = 4'b0;
    assign uart_txd   = 1'b1;
`endif

    always_comb begin
        rdata = '0;
        if (bus.d_oe) begin
            unique case (1'b1)
                ram_hit:   rdata = ram[ram_idx];
                sel_gpio:  rdata = gpio_out;
                sel_timer: rdata = timer;
                sel_ustat: rdata = {12'b0, ustat};
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.d_din = rdata;

endmodule
